// File: rtl/jump_unit_ras.sv
// Registered jump/call/return/branch redirect with a circular return-address stack.
// Define JUMP_UNIT_RAS_EN to build the return stack; otherwise CALL acts as JMP and RET is ignored.
module jump_unit_ras #(
  parameter int ADDR_WIDTH = 16,
  parameter int IMM_WIDTH  = 12,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic                    flush,
  input  logic [15:0]             instruction,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    zero,
  output logic                    jump,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    overflow,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  count
);

  localparam logic [3:0] OP_JMP  = 4'b1111;
  localparam logic [3:0] OP_CALL = 4'b1110;
  localparam logic [3:0] OP_RET  = 4'b1101;
  localparam logic [3:0] OP_BZ   = 4'b1100;

  logic                          accept;
  logic [3:0]                    opcode;
  logic [ADDR_WIDTH-1:0]         abs_target;
  logic [ADDR_WIDTH-1:0]         pc_inc;
  logic [ADDR_WIDTH-1:0]         br_target;
  logic signed [7:0]             br_off;
  logic signed [ADDR_WIDTH-1:0]  br_off_ext;
  logic                          ret_ok;
  logic [ADDR_WIDTH-1:0]         ret_target;
  logic                          jump_p0;
  logic [ADDR_WIDTH-1:0]         address_p0;

  assign accept     = valid_in && !flush;
  assign opcode     = instruction[15:12];
  assign pc_inc     = pc + ADDR_WIDTH'(1);
  assign br_off     = instruction[7:0];
  assign br_off_ext = ADDR_WIDTH'(br_off);
  assign br_target  = pc_inc + br_off_ext;

  always_comb begin
    abs_target = '0;
    abs_target[IMM_WIDTH-1:0] = instruction[IMM_WIDTH-1:0];
  end

`ifdef JUMP_UNIT_RAS_EN
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         sp;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  unf;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(DEPTH)) ? c : c + CW'(1);
  endfunction

  assign push       = accept && (opcode == OP_CALL);
  assign pop        = accept && (opcode == OP_RET);
  assign full       = (cnt == CW'(DEPTH));
  assign empty      = (cnt == '0);
  assign ret_ok     = !empty;
  assign ret_target = mem[sp - PW'(1)];

  // Storage is never reset; only occupancy and pointer are.
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= pc_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push) begin
      sp  <= sp + PW'(1);
      cnt <= sat_inc(cnt);
      if (full) ovf <= 1'b1;
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        sp  <= sp - PW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign count     = cnt;
  assign overflow  = ovf;
  assign underflow = unf;
`else
  assign ret_ok     = 1'b0;
  assign ret_target = '0;
  assign count      = '0;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

  always_comb begin
    jump_p0    = 1'b0;
    address_p0 = '0;
    if (accept) begin
      case (opcode)
        OP_JMP, OP_CALL: begin
          jump_p0    = 1'b1;
          address_p0 = abs_target;
        end
        OP_RET: begin
          if (ret_ok) begin
            jump_p0    = 1'b1;
            address_p0 = ret_target;
          end
        end
        OP_BZ: begin
          if (zero) begin
            jump_p0    = 1'b1;
            address_p0 = br_target;
          end
        end
        default: ;
      endcase
    end
  end

  // p0 -> output register: one-cycle redirect pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump    <= 1'b0;
      address <= '0;
    end else begin
      jump    <= jump_p0;
      address <= address_p0;
    end
  end

endmodule

// File: tb/tb_jump_unit_ras.sv
// Scoreboard bench for jump_unit_ras: driver queues expected outputs, negedge monitor compares.
module tb_jump_unit_ras;

  localparam int AW = 16;
  localparam int CW = 3;

`ifdef JUMP_UNIT_RAS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic          flush = 1'b0;
  logic [15:0]   instruction = '0;
  logic [AW-1:0] pc = '0;
  logic          zero = 1'b0;
  logic          jump;
  logic [AW-1:0] address;
  logic          overflow;
  logic          underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            at;
    string         name;
    logic          jump;
    logic [AW-1:0] address;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t q[$];

  jump_unit_ras #(.ADDR_WIDTH(AW), .IMM_WIDTH(12), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .instruction(instruction), .pc(pc), .zero(zero), .jump(jump),
    .address(address), .overflow(overflow), .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_now(input string name, input logic j, input logic [AW-1:0] a,
                           input logic [CW-1:0] c, input logic o, input logic u);
    checks++;
    if ({jump, address, count, overflow, underflow} !== {j, a, c, o, u}) begin
      errors++;
      $display("FAIL %s: got jump=%b addr=%h count=%0d ovf=%b unf=%b, want jump=%b addr=%h count=%0d ovf=%b unf=%b",
               name, jump, address, count, overflow, underflow, j, a, c, o, u);
    end
  endtask

  // Monitor: compare every expectation tagged for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation missed, cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else begin
        check_now(e.name, e.jump, e.address, e.count, e.ovf, e.unf);
      end
    end
  end

  task automatic step(input string name, input logic v, input logic f, input logic [15:0] ins,
                      input logic [AW-1:0] p, input logic z, input bit chk,
                      input logic ej, input logic [AW-1:0] ea, input logic [CW-1:0] ec,
                      input logic eo, input logic eu);
    exp_t e;
    @(posedge clk);
    #1;
    valid_in = v; flush = f; instruction = ins; pc = p; zero = z;
    if (chk) begin
      e.at = cyc + 1; e.name = name; e.jump = ej; e.address = ea;
      e.count = ec; e.ovf = eo; e.unf = eu;
      q.push_back(e);
    end
  endtask

  task automatic idle(input string name, input logic [CW-1:0] ec, input logic eo, input logic eu);
    step(name, 1'b0, 1'b0, 16'h0000, '0, 1'b0, 1'b1, 1'b0, '0, ec, eo, eu);
  endtask

  initial begin
    logic [AW-1:0] ret_exp [4];
    ret_exp[0] = 16'h0006; ret_exp[1] = 16'h0005; ret_exp[2] = 16'h0004; ret_exp[3] = 16'h0003;

    #12;
    check_now("reset_state", 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    step("jmp", 1, 0, 16'hF02A, 16'd5, 0, 1, 1, 16'h002A, 0, 0, 0);
    idle("jmp_clear", 0, 0, 0);
    step("call", 1, 0, 16'hE100, 16'h0010, 0, 1, 1, 16'h0100, EN ? 3'd1 : 3'd0, 0, 0);
    step("ret_b2b", 1, 0, 16'hD000, 16'h0011, 0, 1, EN, EN ? 16'h0011 : 16'h0000, 0, 0, 0);
    step("bz_taken", 1, 0, 16'hC0FE, 16'h0020, 1, 1, 1, 16'h001F, 0, 0, 0);
    step("bz_not_taken", 1, 0, 16'hC0FE, 16'h0020, 0, 1, 0, 16'h0000, 0, 0, 0);
    step("other_op", 1, 0, 16'h1234, 16'h0030, 1, 1, 0, 16'h0000, 0, 0, 0);
    step("flush_jmp", 1, 1, 16'hF02A, 16'h0031, 0, 1, 0, 16'h0000, 0, 0, 0);

    for (int i = 1; i <= 5; i++) begin
      logic [CW-1:0] c;
      c = EN ? CW'((i > 4) ? 4 : i) : '0;
      step($sformatf("call_fill%0d", i), 1, 0, 16'hE100, AW'(i), 0, 1, 1, 16'h0100, c,
           EN && (i == 5), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step($sformatf("ret_drain%0d", i), 1, 0, 16'hD000, 16'h0050, 0, 1, EN,
           EN ? ret_exp[i] : 16'h0000, EN ? CW'(3 - i) : '0, EN, 0);
    end
    step("ret_empty", 1, 0, 16'hD000, 16'h0050, 0, 1, 0, 16'h0000, 0, EN, EN);
    step("flush_ret", 1, 1, 16'hD000, 16'h0050, 0, 1, 0, 16'h0000, 0, EN, EN);
    step("call_e055", 1, 0, 16'hE055, 16'h0040, 0, 1, 1, 16'h0055, EN ? 3'd1 : 3'd0, EN, EN);
    step("ret_inflight", 1, 0, 16'hD000, 16'h0041, 0, 0, 0, '0, 0, 0, 0);

    // RET registered at this edge; reset must kill it mid-cycle.
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (EN) check_now("ret_pending", 1'b1, 16'h0041, '0, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_now("async_reset", 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    idle("post_reset", 0, 0, 0);
    step("jmp_after_reset", 1, 0, 16'hFFFF, 16'h0000, 0, 1, 1, 16'h0FFF, 0, 0, 0);
    idle("tail", 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
